i2c_clk_gen: RTL and testbench

- Parametrised I2C bit-clock generator with slave clock-stretching.
- Produces SCL (scl_clk) and a quarter-phase-shifted data clock (data_clk) for the byte/bit FSM of the I2C master.
- Beyond the fixed-divider stretcher, it adds:
  - a run-time divider with parameter fallback
  - a synchronised SCL readback
  - a stretch timeout with abort
  - clean start/stop on enable
  - single-cycle edge strobes

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_sync2.sv | 25 ++
 rtl/i2c_clk_gen.sv | 160 ++++++++++++++++
 tb/tb_i2c_clk_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared phase encoding, FSM state type and divider helper for the I2C clock path
package i2c_pkg;

  localparam logic [1:0] PH_LOW_A  = 2'd0;
  localparam logic [1:0] PH_LOW_B  = 2'd1;
  localparam logic [1:0] PH_HIGH_A = 2'd2;
  localparam logic [1:0] PH_HIGH_B = 2'd3;

  localparam int unsigned MIN_DIV       = 4;
  localparam int unsigned STRETCH_GUARD = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Zero means "use the build-time default"; anything shorter than MIN_DIV
  // cannot cover the synchroniser latency plus the stretch guard.
  function automatic int unsigned clamp_div(input int unsigned div, input int unsigned dflt);
    if (div == 0) begin
      return dflt;
    end
    if (div < MIN_DIV) begin
      return MIN_DIV;
    end
    return div;
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// rtl/i2c_sync2.sv - two-flop synchroniser for an open-drain bus line
// Resets to 1 so a released bus never looks like a slave holding the line.
module i2c_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/i2c_clk_gen.sv
// rtl/i2c_clk_gen.sv - I2C SCL / data-clock generator with clock stretching, timeout and edge strobes
// Four quarter-periods per bit; the slave may hold SCL low late in the first high quarter.
module i2c_clk_gen
  import i2c_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 4500,
  parameter int unsigned CBITS       = 15,
  parameter int unsigned TO_CYCLES   = 65535,
  parameter int unsigned TOBITS      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [CBITS-1:0] div_q,
  input  logic             scl_in,
  output logic             scl_clk,
  output logic             data_clk,
  output logic             data_rise,
  output logic             data_fall,
  output logic             busy,
  output logic             stretching,
  output logic             timeout
);

  state_e              state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [CBITS-1:0]    q_cnt_q, q_cnt_d;
  logic [CBITS-1:0]    div_r_q, div_r_d;
  logic [TOBITS-1:0]   str_cnt_q, str_cnt_d;
  logic                timeout_q, timeout_d;
  logic                stretching_q, stretching_d;
  logic                scl_clk_q, scl_clk_d;
  logic                data_clk_q, data_clk_d;
  logic                data_rise_q, data_rise_d;
  logic                data_fall_q, data_fall_d;
  logic                busy_q, busy_d;

  logic                scl_s;
  logic [CBITS-1:0]    sel_div;
  logic                q_last;
  logic                hold;
  logic                run_d;

  i2c_sync2 u_scl_sync (
    .clk (clk),
    .rst (rst),
    .d_i (scl_in),
    .q_o (scl_s)
  );

  assign sel_div = CBITS'(clamp_div(32'(div_q), DEFAULT_DIV));
  assign q_last  = (q_cnt_q == div_r_q - 1'b1);
  // The guard gives the released line time to rise and pass the synchroniser.
  assign hold    = (phase_q == PH_HIGH_A) && (q_cnt_q >= CBITS'(STRETCH_GUARD)) && !scl_s;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    q_cnt_d      = q_cnt_q;
    div_r_d      = div_r_q;
    str_cnt_d    = str_cnt_q;
    timeout_d    = timeout_q;
    stretching_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (timeout_q) begin
          if (!ena) begin
            timeout_d = 1'b0;
          end
        end else if (ena) begin
          state_d   = RUN;
          phase_d   = PH_LOW_A;
          q_cnt_d   = '0;
          div_r_d   = sel_div;
          str_cnt_d = '0;
        end
      end
      RUN: begin
        if (hold) begin
          if (str_cnt_q == TOBITS'(TO_CYCLES - 1)) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            str_cnt_d = '0;
          end else begin
            str_cnt_d    = str_cnt_q + 1'b1;
            stretching_d = 1'b1;
          end
        end else begin
          str_cnt_d = '0;
          if (q_last) begin
            q_cnt_d = '0;
            if (phase_q == PH_HIGH_B) begin
              // A bit always completes; ena is only looked at on the wrap.
              if (ena) begin
                phase_d = PH_LOW_A;
                div_r_d = sel_div;
              end else begin
                state_d = IDLE;
              end
            end else begin
              phase_d = phase_q + 2'd1;
            end
          end else begin
            q_cnt_d = q_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    run_d       = (state_d == RUN);
    busy_d      = run_d;
    scl_clk_d   = run_d ? phase_d[1] : 1'b1;
    data_clk_d  = run_d & (phase_d[1] ^ phase_d[0]);
    data_rise_d = data_clk_d & ~data_clk_q;
    data_fall_d = ~data_clk_d & data_clk_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= PH_LOW_A;
      q_cnt_q      <= '0;
      div_r_q      <= '0;
      str_cnt_q    <= '0;
      timeout_q    <= 1'b0;
      stretching_q <= 1'b0;
      scl_clk_q    <= 1'b1;
      data_clk_q   <= 1'b0;
      data_rise_q  <= 1'b0;
      data_fall_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      q_cnt_q      <= q_cnt_d;
      div_r_q      <= div_r_d;
      str_cnt_q    <= str_cnt_d;
      timeout_q    <= timeout_d;
      stretching_q <= stretching_d;
      scl_clk_q    <= scl_clk_d;
      data_clk_q   <= data_clk_d;
      data_rise_q  <= data_rise_d;
      data_fall_q  <= data_fall_d;
      busy_q       <= busy_d;
    end
  end

  assign scl_clk    = scl_clk_q;
  assign data_clk   = data_clk_q;
  assign data_rise  = data_rise_q;
  assign data_fall  = data_fall_q;
  assign busy       = busy_q;
  assign stretching = stretching_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_i2c_clk_gen.sv
// tb/tb_i2c_clk_gen.sv - self-checking bench for i2c_clk_gen with a bit-position reference model
module tb_i2c_clk_gen;

  localparam int unsigned DDIV = 8;
  localparam int unsigned CB   = 15;
  localparam int unsigned TO   = 24;
  localparam int unsigned TB   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          pull_low = 1'b0;
  logic [CB-1:0] div_q = '0;
  logic          scl_in;
  logic          scl_clk, data_clk, data_rise, data_fall, busy, stretching, timeout;

  // Slave model: open-drain wired-AND of the master drive and a slave pull-down.
  assign scl_in = scl_clk & ~pull_low;

  always #5 clk = ~clk;

  i2c_clk_gen #(
    .DEFAULT_DIV (DDIV),
    .CBITS       (CB),
    .TO_CYCLES   (TO),
    .TOBITS      (TB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .div_q      (div_q),
    .scl_in     (scl_in),
    .scl_clk    (scl_clk),
    .data_clk   (data_clk),
    .data_rise  (data_rise),
    .data_fall  (data_fall),
    .busy       (busy),
    .stretching (stretching),
    .timeout    (timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mchk    = 1'b0;

  logic        m_run = 1'b0, m_to = 1'b0, m_scl = 1'b1, m_data = 1'b0;
  logic        m_rise = 1'b0, m_fall = 1'b0, m_str = 1'b0, m_h0 = 1'b1, m_h1 = 1'b1;
  int unsigned m_t = 0, m_div = DDIV, m_sc = 0;

  typedef struct { int c; logic [6:0] v; } wv_t;
  typedef struct { logic [CB-1:0] d; int first; int per; } dv_t;
  wv_t wt[$];
  dv_t dt[$];

  function automatic logic [6:0] outv();
    return {scl_clk, data_clk, data_rise, data_fall, busy, stretching, timeout};
  endfunction

  function automatic int unsigned eff(input int unsigned d);
    return (d == 0) ? DDIV : ((d < 4) ? 4 : d);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d (0b%0b) expected %0d (0b%0b)", name, cyc, act, act, exp, exp);
    end
  endtask

  // Position-in-bit model: phase = t / div, quarter count = t % div.
  task automatic model_step();
    logic sin, ss, prev;
    int unsigned ph, q;
    sin   = m_scl & ~pull_low;
    ss    = m_h1;
    prev  = m_data;
    m_str = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_to = 1'b0; m_sc = 0; m_t = 0; m_h0 = 1'b1; m_h1 = 1'b1;
    end else begin
      m_h1 = m_h0;
      m_h0 = sin;
      if (!m_run) begin
        if (m_to) begin
          if (!ena) m_to = 1'b0;
        end else if (ena) begin
          m_run = 1'b1; m_t = 0; m_div = eff(div_q); m_sc = 0;
        end
      end else begin
        ph = m_t / m_div;
        q  = m_t % m_div;
        if (ph == 2 && q >= 3 && !ss) begin
          m_sc++;
          if (m_sc == TO) begin
            m_to = 1'b1; m_run = 1'b0; m_sc = 0;
          end else begin
            m_str = 1'b1;
          end
        end else begin
          m_sc = 0;
          m_t++;
          if (m_t == 4 * m_div) begin
            if (ena) begin
              m_t = 0; m_div = eff(div_q);
            end else begin
              m_run = 1'b0;
            end
          end
        end
      end
    end
    if (m_run) begin
      ph     = m_t / m_div;
      m_scl  = (ph >= 2);
      m_data = (ph == 1) || (ph == 2);
    end else begin
      m_scl  = 1'b1;
      m_data = 1'b0;
    end
    m_rise = m_data & ~prev & ~rst;
    m_fall = ~m_data & prev & ~rst;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    if (mchk) chk("model", outv(), {m_scl, m_data, m_rise, m_fall, m_run, m_str, m_to});
  endtask

  task automatic start_run(input logic [CB-1:0] d);
    pull_low = 1'b0;
    rst = 1'b1;
    step();
    rst   = 1'b0;
    ena   = 1'b1;
    div_q = d;
    step();
    cyc = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic next_rise(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (data_rise) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t0, t1, nstr, first_str, fall_at, rise_at, burst;

    wt.push_back('{0,  7'b0000100});
    wt.push_back('{7,  7'b0000100});
    wt.push_back('{8,  7'b0110100});
    wt.push_back('{9,  7'b0100100});
    wt.push_back('{15, 7'b0100100});
    wt.push_back('{16, 7'b1100100});
    wt.push_back('{23, 7'b1100100});
    wt.push_back('{24, 7'b1001100});
    wt.push_back('{25, 7'b1000100});
    wt.push_back('{31, 7'b1000100});
    wt.push_back('{32, 7'b0000100});
    wt.push_back('{40, 7'b0110100});

    dt.push_back('{15'd0, 8, 32});
    dt.push_back('{15'd5, 5, 20});
    dt.push_back('{15'd2, 4, 16});
    dt.push_back('{15'd1, 4, 16});
    dt.push_back('{15'd4, 4, 16});
    dt.push_back('{15'd7, 7, 28});
    dt.push_back('{15'd9, 9, 36});

    @(negedge clk);
    rst = 1'b1;
    step();
    mchk = 1'b1;
    chk("reset_outputs", outv(), 7'b1000000);

    start_run(15'd0);
    for (int c = 0; c <= 40; c++) begin
      foreach (wt[i]) if (wt[i].c == c) chk("waveform", outv(), wt[i].v);
      step();
    end

    foreach (dt[i]) begin
      start_run(dt[i].d);
      next_rise(t0);
      next_rise(t1);
      chk("first_rise", t0, dt[i].first);
      chk("period", t1 - t0, dt[i].per);
    end

    start_run(15'd0);
    run_to(10);
    div_q = 15'd5;
    next_rise(t0);
    next_rise(t1);
    chk("divchg_rise2", t0, 37);
    chk("divchg_rise3", t1, 57);

    start_run(15'd0);
    run_to(12);
    pull_low = 1'b1;
    nstr = 0; first_str = -1; fall_at = -1; rise_at = -1;
    while (cyc < 70) begin
      if (cyc == 37) pull_low = 1'b0;
      step();
      if (stretching) begin
        nstr++;
        if (first_str < 0) first_str = cyc;
      end
      if (data_fall && fall_at < 0) fall_at = cyc;
      if (data_rise && rise_at < 0) rise_at = cyc;
    end
    chk("stretch_start", first_str, 20);
    chk("stretch_len", nstr, 20);
    chk("stretch_fall", fall_at, 44);
    chk("stretch_next_rise", rise_at, 60);
    chk("stretch_no_timeout", timeout, 0);

    start_run(15'd0);
    run_to(12);
    pull_low = 1'b1;
    run_to(42);
    chk("pre_timeout", outv(), 7'b1100110);
    step();
    chk("timeout_exit", outv(), 7'b1001001);
    run_to(53);
    chk("timeout_ignores_ena", outv(), 7'b1000001);
    ena = 1'b0;
    step();
    chk("timeout_clear", outv(), 7'b1000000);
    pull_low = 1'b0;
    ena = 1'b1;
    step();
    chk("restart_after_timeout", outv(), 7'b0000100);

    start_run(15'd0);
    run_to(10);
    ena = 1'b0;
    run_to(31);
    chk("stop_busy_last", busy, 1);
    step();
    chk("stop_idle", outv(), 7'b1000000);

    start_run(15'd0);
    run_to(10);
    ena = 1'b0;
    run_to(31);
    ena = 1'b1;
    step();
    chk("reassert_continue", outv(), 7'b0000100);

    start_run(15'd0);
    run_to(12);
    pull_low = 1'b1;
    run_to(25);
    chk("mid_stretch", stretching, 1);
    rst = 1'b1;
    step();
    chk("reset_mid_stretch", outv(), 7'b1000000);
    rst = 1'b0;
    pull_low = 1'b0;

    burst = 0;
    ena = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 149) == 0) ena = ~ena;
      if ($urandom_range(0, 39) == 0) div_q = CB'($urandom_range(0, 9));
      if (burst > 0) begin
        burst--;
        if (burst == 0) pull_low = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        pull_low = 1'b1;
        burst = $urandom_range(1, 35);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
